// File: rtl/d_mem_axi_responder_if.sv
// ---------------------------------------------------------------------------
// d_mem_axi_responder_if
//
// Purpose: bundles the AXI-Lite-style data-cache port between the core's
// data-cache master and the d_mem_axi_responder memory model.
//
// Signals:
//   AW channel : AXI_AWVALID, AXI_AWADDR, AXI_AWPROT, AXI_AWCACHE, AXI_AWREADY
//   W  channel : AXI_WVALID, AXI_WDATA, AXI_WSTRB, WR_Byte, WR_HWORD, AXI_WREADY
//   B  channel : AXI_BVALID, AXI_BRESP, AXI_BREADY
//   AR channel : AXI_ARVALID, AXI_ARADDR, AXI_ARPROT, AXI_ARCACHE, AXI_ARREADY
//   R  channel : AXI_RVALID, AXI_RDATA (D_WORD words), AXI_RRESP, AXI_RREADY
//
// Modports:
//   master : cache side (drives VALIDs, addresses, data, B/R READYs)
//   slave  : memory side (drives AW/W/AR READYs, B and R responses)
// ---------------------------------------------------------------------------
interface d_mem_axi_responder_if #(
    parameter int XLEN   = 32,
    parameter int D_WORD = 4
);
    logic                   AXI_AWVALID;
    logic [XLEN-1:0]        AXI_AWADDR;
    logic [2:0]             AXI_AWPROT;
    logic [3:0]             AXI_AWCACHE;
    logic                   AXI_AWREADY;

    logic                   AXI_WVALID;
    logic [XLEN-1:0]        AXI_WDATA;
    logic [3:0]             AXI_WSTRB;
    logic                   WR_Byte;
    logic                   WR_HWORD;
    logic                   AXI_WREADY;

    logic                   AXI_BVALID;
    logic [1:0]             AXI_BRESP;
    logic                   AXI_BREADY;

    logic                   AXI_ARVALID;
    logic [XLEN-1:0]        AXI_ARADDR;
    logic [2:0]             AXI_ARPROT;
    logic [3:0]             AXI_ARCACHE;
    logic                   AXI_ARREADY;

    logic                   AXI_RVALID;
    logic [XLEN*D_WORD-1:0] AXI_RDATA;
    logic [1:0]             AXI_RRESP;
    logic                   AXI_RREADY;

    modport master (
        output AXI_AWVALID, AXI_AWADDR, AXI_AWPROT, AXI_AWCACHE,
        input  AXI_AWREADY,
        output AXI_WVALID, AXI_WDATA, AXI_WSTRB, WR_Byte, WR_HWORD,
        input  AXI_WREADY,
        input  AXI_BVALID, AXI_BRESP,
        output AXI_BREADY,
        output AXI_ARVALID, AXI_ARADDR, AXI_ARPROT, AXI_ARCACHE,
        input  AXI_ARREADY,
        input  AXI_RVALID, AXI_RDATA, AXI_RRESP,
        output AXI_RREADY
    );

    modport slave (
        input  AXI_AWVALID, AXI_AWADDR, AXI_AWPROT, AXI_AWCACHE,
        output AXI_AWREADY,
        input  AXI_WVALID, AXI_WDATA, AXI_WSTRB, WR_Byte, WR_HWORD,
        output AXI_WREADY,
        output AXI_BVALID, AXI_BRESP,
        input  AXI_BREADY,
        input  AXI_ARVALID, AXI_ARADDR, AXI_ARPROT, AXI_ARCACHE,
        output AXI_ARREADY,
        output AXI_RVALID, AXI_RDATA, AXI_RRESP,
        input  AXI_RREADY
    );
endinterface

// File: rtl/d_mem_axi_responder.sv
// ---------------------------------------------------------------------------
// d_mem_axi_responder
//
// Purpose: AXI-Lite-style slave memory that terminates the data-cache port of
// the RV32IMF core. Single-word writes (with byte/halfword qualifiers) go in
// through AW/W/B; every AR is answered with a whole D_WORD-word cache line on
// R after RD_LATENCY idle cycles.
//
// Ports:
//   CLK  - clock
//   rst  - synchronous active-high reset; forces every output to 0 and
//          returns both FSMs to idle (memory contents are kept)
//   axi  - d_mem_axi_responder_if.slave bundle (AW, W, B, AR, R channels)
//
// Responses: 00 OKAY, 10 SLVERR (misaligned halfword write),
//            11 DECERR (word index beyond DEPTH_WORDS).
// ---------------------------------------------------------------------------
module d_mem_axi_responder #(
    parameter int XLEN        = 32,
    parameter int D_WORD      = 4,
    parameter int DEPTH_WORDS = 1024,
    parameter int RD_LATENCY  = 2
) (
    input logic                  CLK,
    input logic                  rst,
    d_mem_axi_responder_if.slave axi
);

    localparam int              IDX_W      = $clog2(DEPTH_WORDS);
    localparam int              CNT_W      = (RD_LATENCY > 0) ? $clog2(RD_LATENCY + 1) : 1;
    localparam logic [XLEN-1:0] DEPTH_L    = XLEN'(DEPTH_WORDS);
    localparam logic [XLEN-1:0] LINE_MASK  = ~(XLEN'(D_WORD * 4) - XLEN'(1));
    localparam logic [1:0]      RESP_OKAY  = 2'b00;
    localparam logic [1:0]      RESP_SLV   = 2'b10;
    localparam logic [1:0]      RESP_DEC   = 2'b11;

    typedef enum logic {
        W_IDLE,
        W_RESP
    } w_state_e;

    typedef enum logic [1:0] {
        R_IDLE,
        R_WAIT,
        R_DATA
    } r_state_e;

    logic [XLEN-1:0] mem [DEPTH_WORDS];

    // ------------------------------------------------------------------
    // Write channel state
    // ------------------------------------------------------------------
    w_state_e        w_state_q, w_state_d;
    logic            aw_full_q, aw_full_d;
    logic [XLEN-1:0] aw_addr_q, aw_addr_d;
    logic            w_full_q, w_full_d;
    logic [XLEN-1:0] w_data_q, w_data_d;
    logic [3:0]      w_strb_q, w_strb_d;
    logic            w_byte_q, w_byte_d;
    logic            w_hword_q, w_hword_d;
    logic [1:0]      bresp_q, bresp_d;

    logic            awready, wready, bvalid;
    logic            aw_hs, w_hs;
    logic [XLEN-1:0] cur_addr, cur_data;
    logic [3:0]      cur_strb;
    logic            cur_byte, cur_hword;
    logic [XLEN-1:0] wr_idx;
    logic [3:0]      wr_be;
    logic [XLEN-1:0] wr_word;
    logic [1:0]      wr_resp;
    logic            commit_go, commit_en;

    // ------------------------------------------------------------------
    // Read channel state
    // ------------------------------------------------------------------
    r_state_e               r_state_q, r_state_d;
    logic [XLEN-1:0]        r_base_q, r_base_d;
    logic [CNT_W-1:0]       r_cnt_q, r_cnt_d;
    logic [XLEN*D_WORD-1:0] rdata_q, rdata_d;
    logic [1:0]             rresp_q, rresp_d;

    logic                   arready, rvalid, ar_hs;
    logic [XLEN-1:0]        ar_base, line_base, line_idx;
    logic [XLEN*D_WORD-1:0] line_data;
    logic                   line_err;

    logic                   unused_bits;

    // Outputs decode the registered FSM state; rst masks them so that every
    // output is 0 for as long as reset is held.
    assign awready = !rst && (w_state_q == W_IDLE) && !aw_full_q;
    assign wready  = !rst && (w_state_q == W_IDLE) && !w_full_q;
    assign bvalid  = !rst && (w_state_q == W_RESP);
    assign arready = !rst && (r_state_q == R_IDLE);
    assign rvalid  = !rst && (r_state_q == R_DATA);

    assign axi.AXI_AWREADY = awready;
    assign axi.AXI_WREADY  = wready;
    assign axi.AXI_BVALID  = bvalid;
    assign axi.AXI_BRESP   = bvalid ? bresp_q : 2'b00;
    assign axi.AXI_ARREADY = arready;
    assign axi.AXI_RVALID  = rvalid;
    assign axi.AXI_RDATA   = rvalid ? rdata_q : '0;
    assign axi.AXI_RRESP   = rvalid ? rresp_q : 2'b00;

    assign aw_hs = awready && axi.AXI_AWVALID;
    assign w_hs  = wready && axi.AXI_WVALID;
    assign ar_hs = arready && axi.AXI_ARVALID;

    // The write commits on the edge where the second of AW/W is accepted, so
    // whichever half is not latched yet is taken straight from the bus.
    always_comb begin
        cur_addr  = aw_full_q ? aw_addr_q : axi.AXI_AWADDR;
        cur_data  = w_full_q ? w_data_q : axi.AXI_WDATA;
        cur_strb  = w_full_q ? w_strb_q : axi.AXI_WSTRB;
        cur_byte  = w_full_q ? w_byte_q : axi.WR_Byte;
        cur_hword = w_full_q ? w_hword_q : axi.WR_HWORD;
        commit_go = (w_state_q == W_IDLE) && (aw_full_q || aw_hs) && (w_full_q || w_hs);
    end

    // Lane selection: byte qualifier beats halfword, and the narrow data is
    // replicated across the word so the byte enables alone pick the lane.
    always_comb begin
        wr_idx  = {2'b00, cur_addr[XLEN-1:2]};
        wr_be   = cur_strb;
        wr_word = cur_data;
        wr_resp = RESP_OKAY;
        if (cur_byte) begin
            wr_be   = 4'b0001 << cur_addr[1:0];
            wr_word = {4{cur_data[7:0]}};
        end else if (cur_hword) begin
            wr_be   = cur_addr[1] ? 4'b1100 : 4'b0011;
            wr_word = {2{cur_data[15:0]}};
        end
        if (wr_idx >= DEPTH_L) begin
            wr_resp = RESP_DEC;
        end else if (!cur_byte && cur_hword && cur_addr[0]) begin
            wr_resp = RESP_SLV;
        end
        commit_en = commit_go && (wr_resp == RESP_OKAY);
    end

    // Write FSM next state: latch each channel on its own handshake, go to
    // W_RESP once both halves are present, and clear the latches on B.
    always_comb begin
        w_state_d = w_state_q;
        aw_full_d = aw_full_q;
        aw_addr_d = aw_addr_q;
        w_full_d  = w_full_q;
        w_data_d  = w_data_q;
        w_strb_d  = w_strb_q;
        w_byte_d  = w_byte_q;
        w_hword_d = w_hword_q;
        bresp_d   = bresp_q;
        case (w_state_q)
            W_IDLE: begin
                if (aw_hs) begin
                    aw_full_d = 1'b1;
                    aw_addr_d = axi.AXI_AWADDR;
                end
                if (w_hs) begin
                    w_full_d  = 1'b1;
                    w_data_d  = axi.AXI_WDATA;
                    w_strb_d  = axi.AXI_WSTRB;
                    w_byte_d  = axi.WR_Byte;
                    w_hword_d = axi.WR_HWORD;
                end
                if (commit_go) begin
                    w_state_d = W_RESP;
                    bresp_d   = wr_resp;
                end
            end
            W_RESP: begin
                if (axi.AXI_BREADY) begin
                    w_state_d = W_IDLE;
                    aw_full_d = 1'b0;
                    w_full_d  = 1'b0;
                    bresp_d   = RESP_OKAY;
                end
            end
            default: w_state_d = W_IDLE;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (rst) begin
            w_state_q <= W_IDLE;
            aw_full_q <= 1'b0;
            aw_addr_q <= '0;
            w_full_q  <= 1'b0;
            w_data_q  <= '0;
            w_strb_q  <= 4'b0000;
            w_byte_q  <= 1'b0;
            w_hword_q <= 1'b0;
            bresp_q   <= RESP_OKAY;
        end else begin
            w_state_q <= w_state_d;
            aw_full_q <= aw_full_d;
            aw_addr_q <= aw_addr_d;
            w_full_q  <= w_full_d;
            w_data_q  <= w_data_d;
            w_strb_q  <= w_strb_d;
            w_byte_q  <= w_byte_d;
            w_hword_q <= w_hword_d;
            bresp_q   <= bresp_d;
        end
    end

    // Memory array is never reset; commit_en is already false under rst
    // because the handshakes that feed it are masked.
    always_ff @(posedge CLK) begin
        if (commit_en) begin
            for (int b = 0; b < 4; b++) begin
                if (wr_be[b]) begin
                    mem[wr_idx[IDX_W-1:0]][8*b +: 8] <= wr_word[8*b +: 8];
                end
            end
        end
    end

    // Line fetch. In R_IDLE the address comes straight off AR so that a
    // zero-latency build can capture on the handshake edge itself. Words past
    // the end of the array read as zero and flag the line as DECERR.
    always_comb begin
        ar_base   = axi.AXI_ARADDR & LINE_MASK;
        line_base = (r_state_q == R_IDLE) ? ar_base : r_base_q;
        line_data = '0;
        line_err  = 1'b0;
        line_idx  = '0;
        for (int i = 0; i < D_WORD; i++) begin
            line_idx = {2'b00, line_base[XLEN-1:2]} + XLEN'(i);
            if (line_idx < DEPTH_L) begin
                line_data[XLEN*i +: XLEN] = mem[line_idx[IDX_W-1:0]];
            end else begin
                line_err = 1'b1;
            end
        end
    end

    // Read FSM next state. The line is sampled on the edge that enters
    // R_DATA, so a write committing on that same edge is not seen.
    always_comb begin
        r_state_d = r_state_q;
        r_base_d  = r_base_q;
        r_cnt_d   = r_cnt_q;
        rdata_d   = rdata_q;
        rresp_d   = rresp_q;
        case (r_state_q)
            R_IDLE: begin
                if (ar_hs) begin
                    r_base_d = ar_base;
                    r_cnt_d  = CNT_W'(RD_LATENCY);
                    if (RD_LATENCY == 0) begin
                        r_state_d = R_DATA;
                        rdata_d   = line_data;
                        rresp_d   = line_err ? RESP_DEC : RESP_OKAY;
                    end else begin
                        r_state_d = R_WAIT;
                    end
                end
            end
            R_WAIT: begin
                r_cnt_d = r_cnt_q - CNT_W'(1);
                if (r_cnt_q <= CNT_W'(1)) begin
                    r_state_d = R_DATA;
                    rdata_d   = line_data;
                    rresp_d   = line_err ? RESP_DEC : RESP_OKAY;
                end
            end
            R_DATA: begin
                if (axi.AXI_RREADY) begin
                    r_state_d = R_IDLE;
                end
            end
            default: r_state_d = R_IDLE;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (rst) begin
            r_state_q <= R_IDLE;
            r_base_q  <= '0;
            r_cnt_q   <= '0;
            rdata_q   <= '0;
            rresp_q   <= RESP_OKAY;
        end else begin
            r_state_q <= r_state_d;
            r_base_q  <= r_base_d;
            r_cnt_q   <= r_cnt_d;
            rdata_q   <= rdata_d;
            rresp_q   <= rresp_d;
        end
    end

    // Protection/cache attributes carry no meaning for this model.
    assign unused_bits = ^{axi.AXI_AWPROT, axi.AXI_AWCACHE, axi.AXI_ARPROT,
                           axi.AXI_ARCACHE, line_base[1:0]};

endmodule

// File: tb/tb_d_mem_axi_responder.sv
// ---------------------------------------------------------------------------
// tb_d_mem_axi_responder
//
// Directed bench for d_mem_axi_responder: one instance with RD_LATENCY=2 for
// the bulk of the sequence and a second with RD_LATENCY=0 for the
// zero-latency read path. Expected values are written out by hand.
// ---------------------------------------------------------------------------
module tb_d_mem_axi_responder;

    logic         clk;
    logic         rst;
    int           checks;
    int           errors;
    logic [127:0] lastLine;
    int           lastLat;

    d_mem_axi_responder_if #(.XLEN(32), .D_WORD(4)) bus ();
    d_mem_axi_responder_if #(.XLEN(32), .D_WORD(4)) bus0 ();

    d_mem_axi_responder #(
        .XLEN(32), .D_WORD(4), .DEPTH_WORDS(1024), .RD_LATENCY(2)
    ) dut (
        .CLK (clk),
        .rst (rst),
        .axi (bus)
    );

    d_mem_axi_responder #(
        .XLEN(32), .D_WORD(4), .DEPTH_WORDS(1024), .RD_LATENCY(0)
    ) dut0 (
        .CLK (clk),
        .rst (rst),
        .axi (bus0)
    );

    // Free-running 10 ns clock
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Safety net so a wedged run still ends
    initial begin
        #200000;
        $display("[TB] FAIL watchdog expired");
        $fatal(1, "[TB] watchdog");
    end

    // Advance to just after the next rising edge; inputs are driven and
    // outputs sampled at this point, well away from the edge itself.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One comparison: counts it, and on mismatch counts and reports it
    task automatic checkOutput(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Drive the AW and W channels of the main instance
    task automatic applyStimulus(input logic awv, input logic [31:0] awaddr,
                                 input logic wv, input logic [31:0] wdata,
                                 input logic [3:0] wstrb, input logic wbyte,
                                 input logic whword);
        bus.AXI_AWVALID = awv;
        bus.AXI_AWADDR  = awaddr;
        bus.AXI_WVALID  = wv;
        bus.AXI_WDATA   = wdata;
        bus.AXI_WSTRB   = wstrb;
        bus.WR_Byte     = wbyte;
        bus.WR_HWORD    = whword;
    endtask

    // AW and W in the same cycle; BVALID must follow on the next cycle.
    // Assumes BREADY=1 so the response completes on the following edge.
    task automatic writeTxn(input logic [31:0] addr, input logic [31:0] data,
                            input logic [3:0] strb, input logic wbyte,
                            input logic whword, input logic [1:0] expResp,
                            input string tag);
        checkOutput({tag, "_awready"}, 128'(bus.AXI_AWREADY), 128'(1'b1));
        applyStimulus(1'b1, addr, 1'b1, data, strb, wbyte, whword);
        tick();
        applyStimulus(1'b0, 32'h0, 1'b0, 32'h0, 4'h0, 1'b0, 1'b0);
        checkOutput({tag, "_bvalid"}, 128'(bus.AXI_BVALID), 128'(1'b1));
        checkOutput({tag, "_bresp"}, 128'(bus.AXI_BRESP), 128'(expResp));
        tick();
    endtask

    // Issue AR, wait a bounded number of cycles for RVALID, check latency and
    // RRESP, and leave the captured line in lastLine. Leaves the bench one
    // cycle past the RVALID cycle.
    task automatic readLine(input logic [31:0] addr, input logic [1:0] expResp,
                            input string tag);
        checkOutput({tag, "_arready"}, 128'(bus.AXI_ARREADY), 128'(1'b1));
        bus.AXI_ARVALID = 1'b1;
        bus.AXI_ARADDR  = addr;
        tick();
        bus.AXI_ARVALID = 1'b0;
        lastLat = 0;
        for (int k = 1; k <= 10; k++) begin
            if (bus.AXI_RVALID === 1'b1) begin
                lastLat = k;
                break;
            end
            tick();
        end
        checkOutput({tag, "_lat"}, 128'(lastLat), 128'(3));
        lastLine = bus.AXI_RDATA;
        checkOutput({tag, "_rresp"}, 128'(bus.AXI_RRESP), 128'(expResp));
        tick();
    endtask

    // Whole directed sequence
    initial begin
        checks = 0;
        errors = 0;
        lastLine = '0;
        lastLat = 0;
        rst = 1'b1;
        applyStimulus(1'b0, 32'h0, 1'b0, 32'h0, 4'h0, 1'b0, 1'b0);
        bus.AXI_AWPROT = 3'h0;  bus.AXI_AWCACHE = 4'h0;
        bus.AXI_ARPROT = 3'h0;  bus.AXI_ARCACHE = 4'h0;
        bus.AXI_BREADY = 1'b1;  bus.AXI_RREADY  = 1'b1;
        bus.AXI_ARVALID = 1'b0; bus.AXI_ARADDR  = 32'h0;
        bus0.AXI_AWVALID = 1'b0; bus0.AXI_AWADDR = 32'h0;
        bus0.AXI_AWPROT = 3'h0;  bus0.AXI_AWCACHE = 4'h0;
        bus0.AXI_WVALID = 1'b0;  bus0.AXI_WDATA = 32'h0; bus0.AXI_WSTRB = 4'h0;
        bus0.WR_Byte = 1'b0;     bus0.WR_HWORD = 1'b0;
        bus0.AXI_BREADY = 1'b1;  bus0.AXI_RREADY = 1'b1;
        bus0.AXI_ARVALID = 1'b0; bus0.AXI_ARADDR = 32'h0;
        bus0.AXI_ARPROT = 3'h0;  bus0.AXI_ARCACHE = 4'h0;

        // Reset: every output low while rst is held
        tick();
        tick();
        checkOutput("rst_awready", 128'(bus.AXI_AWREADY), 128'(1'b0));
        checkOutput("rst_wready",  128'(bus.AXI_WREADY),  128'(1'b0));
        checkOutput("rst_bvalid",  128'(bus.AXI_BVALID),  128'(1'b0));
        checkOutput("rst_bresp",   128'(bus.AXI_BRESP),   128'(2'b00));
        checkOutput("rst_arready", 128'(bus.AXI_ARREADY), 128'(1'b0));
        checkOutput("rst_rvalid",  128'(bus.AXI_RVALID),  128'(1'b0));
        checkOutput("rst_rresp",   128'(bus.AXI_RRESP),   128'(2'b00));
        checkOutput("rst_rdata",   bus.AXI_RDATA,         128'h0);

        // Out of reset: idle with all READYs up
        rst = 1'b0;
        tick();
        $display("[TB] reset released");
        checkOutput("idle_awready", 128'(bus.AXI_AWREADY), 128'(1'b1));
        checkOutput("idle_wready",  128'(bus.AXI_WREADY),  128'(1'b1));
        checkOutput("idle_arready", 128'(bus.AXI_ARREADY), 128'(1'b1));

        // Full word write then line read from inside the same line
        writeTxn(32'h40, 32'hDEADBEEF, 4'hF, 1'b0, 1'b0, 2'b00, "wr40");
        readLine(32'h48, 2'b00, "rd48");
        checkOutput("rd48_w0", 128'(lastLine[31:0]), 128'(32'hDEADBEEF));

        // Byte / halfword lanes, misaligned halfword, byte-over-halfword
        writeTxn(32'h41, 32'h00000055, 4'h0, 1'b1, 1'b0, 2'b00, "wrb41");
        readLine(32'h40, 2'b00, "rdb41");
        checkOutput("rdb41_w0", 128'(lastLine[31:0]), 128'(32'hDEAD55EF));
        writeTxn(32'h42, 32'h00001234, 4'h0, 1'b0, 1'b1, 2'b00, "wrh42");
        writeTxn(32'h43, 32'h0000ABCD, 4'hF, 1'b0, 1'b1, 2'b10, "wrh43");
        readLine(32'h40, 2'b00, "rdh43");
        checkOutput("rdh43_w0", 128'(lastLine[31:0]), 128'(32'h123455EF));
        writeTxn(32'h43, 32'h0000009A, 4'h0, 1'b1, 1'b1, 2'b00, "wrbh43");

        // W beat two cycles ahead of AW, then a stalled B response
        applyStimulus(1'b0, 32'h0, 1'b1, 32'hA5A50F0F, 4'hF, 1'b0, 1'b0);
        tick();
        applyStimulus(1'b0, 32'h0, 1'b0, 32'h0, 4'h0, 1'b0, 1'b0);
        checkOutput("wfirst_wready",  128'(bus.AXI_WREADY),  128'(1'b0));
        checkOutput("wfirst_awready", 128'(bus.AXI_AWREADY), 128'(1'b1));
        tick();
        checkOutput("wfirst_bvalid", 128'(bus.AXI_BVALID), 128'(1'b0));
        bus.AXI_BREADY = 1'b0;
        applyStimulus(1'b1, 32'h44, 1'b0, 32'h0, 4'h0, 1'b0, 1'b0);
        tick();
        applyStimulus(1'b0, 32'h0, 1'b0, 32'h0, 4'h0, 1'b0, 1'b0);
        for (int k = 0; k < 5; k++) begin
            checkOutput("bhold_bvalid",  128'(bus.AXI_BVALID),  128'(1'b1));
            checkOutput("bhold_bresp",   128'(bus.AXI_BRESP),   128'(2'b00));
            checkOutput("bhold_awready", 128'(bus.AXI_AWREADY), 128'(1'b0));
            checkOutput("bhold_wready",  128'(bus.AXI_WREADY),  128'(1'b0));
            tick();
        end
        bus.AXI_BREADY = 1'b1;
        tick();
        checkOutput("brel_bvalid",  128'(bus.AXI_BVALID),  128'(1'b0));
        checkOutput("brel_awready", 128'(bus.AXI_AWREADY), 128'(1'b1));

        // Same-cycle AW/W, and WSTRB masking
        writeTxn(32'h48, 32'hA5A50F0F, 4'hF, 1'b0, 1'b0, 2'b00, "wr48");
        writeTxn(32'h4C, 32'h11223344, 4'hF, 1'b0, 1'b0, 2'b00, "wr4c");
        writeTxn(32'h4C, 32'hAABBCCDD, 4'b0101, 1'b0, 1'b0, 2'b00, "wr4cs");
        readLine(32'h4C, 2'b00, "rd40");
        checkOutput("rd40_w0", 128'(lastLine[31:0]),   128'(32'h9A3455EF));
        checkOutput("rd40_w1", 128'(lastLine[63:32]),  128'(32'hA5A50F0F));
        checkOutput("rd40_w2", 128'(lastLine[95:64]),  128'(32'hA5A50F0F));
        checkOutput("rd40_w3", 128'(lastLine[127:96]), 128'(32'h11BB33DD));

        // Out-of-range write must not alias onto word 0
        writeTxn(32'h0, 32'h0BADF00D, 4'hF, 1'b0, 1'b0, 2'b00, "wr00");
        writeTxn(32'h1000, 32'h12345678, 4'hF, 1'b0, 1'b0, 2'b11, "wroor");
        readLine(32'h0, 2'b00, "rd00");
        checkOutput("rd00_w0", 128'(lastLine[31:0]), 128'(32'h0BADF00D));
        readLine(32'h1000, 2'b11, "rdoor");
        checkOutput("rdoor_data", lastLine, 128'h0);

        // RREADY held low: data and RVALID stay put
        bus.AXI_RREADY = 1'b0;
        readLine(32'h40, 2'b00, "rstall");
        for (int k = 0; k < 4; k++) begin
            checkOutput("rstall_rvalid", 128'(bus.AXI_RVALID), 128'(1'b1));
            checkOutput("rstall_rdata",  bus.AXI_RDATA,        lastLine);
            tick();
        end
        bus.AXI_RREADY = 1'b1;
        tick();
        checkOutput("rstall_done", 128'(bus.AXI_RVALID), 128'(1'b0));

        // Write committing during R_WAIT is visible in the line
        writeTxn(32'h50, 32'h01010101, 4'hF, 1'b0, 1'b0, 2'b00, "wr50");
        writeTxn(32'h54, 32'h02020202, 4'hF, 1'b0, 1'b0, 2'b00, "wr54");
        bus.AXI_ARVALID = 1'b1;
        bus.AXI_ARADDR  = 32'h50;
        tick();
        bus.AXI_ARVALID = 1'b0;
        applyStimulus(1'b1, 32'h50, 1'b1, 32'h600DCAFE, 4'hF, 1'b0, 1'b0);
        tick();
        applyStimulus(1'b0, 32'h0, 1'b0, 32'h0, 4'h0, 1'b0, 1'b0);
        tick();
        checkOutput("rwait_rvalid", 128'(bus.AXI_RVALID), 128'(1'b1));
        checkOutput("rwait_w0", 128'(bus.AXI_RDATA[31:0]), 128'(32'h600DCAFE));
        tick();

        // Write committing on the R_DATA entry edge is not visible
        bus.AXI_ARVALID = 1'b1;
        bus.AXI_ARADDR  = 32'h50;
        tick();
        bus.AXI_ARVALID = 1'b0;
        tick();
        applyStimulus(1'b1, 32'h54, 1'b1, 32'h77777777, 4'hF, 1'b0, 1'b0);
        tick();
        applyStimulus(1'b0, 32'h0, 1'b0, 32'h0, 4'h0, 1'b0, 1'b0);
        checkOutput("rold_rvalid", 128'(bus.AXI_RVALID), 128'(1'b1));
        checkOutput("rold_bvalid", 128'(bus.AXI_BVALID), 128'(1'b1));
        checkOutput("rold_w1", 128'(bus.AXI_RDATA[63:32]), 128'(32'h02020202));
        tick();
        readLine(32'h50, 2'b00, "rnew");
        checkOutput("rnew_w1", 128'(lastLine[63:32]), 128'(32'h77777777));

        // Reset while write is in W_RESP and read is in R_WAIT
        writeTxn(32'h64, 32'h00000000, 4'hF, 1'b0, 1'b0, 2'b00, "wr64");
        bus.AXI_BREADY  = 1'b0;
        bus.AXI_ARVALID = 1'b1;
        bus.AXI_ARADDR  = 32'h40;
        applyStimulus(1'b1, 32'h60, 1'b1, 32'h33333333, 4'hF, 1'b0, 1'b0);
        tick();
        bus.AXI_ARVALID = 1'b0;
        applyStimulus(1'b0, 32'h0, 1'b0, 32'h0, 4'h0, 1'b0, 1'b0);
        checkOutput("rstmid_bvalid", 128'(bus.AXI_BVALID), 128'(1'b1));
        rst = 1'b1;
        tick();
        checkOutput("rstmid_awready0", 128'(bus.AXI_AWREADY), 128'(1'b0));
        checkOutput("rstmid_bvalid0",  128'(bus.AXI_BVALID),  128'(1'b0));
        checkOutput("rstmid_arready0", 128'(bus.AXI_ARREADY), 128'(1'b0));
        checkOutput("rstmid_rvalid0",  128'(bus.AXI_RVALID),  128'(1'b0));
        rst = 1'b0;
        #1;
        checkOutput("rstmid_awready", 128'(bus.AXI_AWREADY), 128'(1'b1));
        checkOutput("rstmid_bvalid",  128'(bus.AXI_BVALID),  128'(1'b0));
        checkOutput("rstmid_arready", 128'(bus.AXI_ARREADY), 128'(1'b1));
        tick();
        checkOutput("rstmid_rvalid", 128'(bus.AXI_RVALID), 128'(1'b0));
        bus.AXI_BREADY = 1'b1;

        // Reset with only the W beat latched: nothing reaches memory
        applyStimulus(1'b0, 32'h0, 1'b1, 32'h44444444, 4'hF, 1'b0, 1'b0);
        tick();
        applyStimulus(1'b0, 32'h0, 1'b0, 32'h0, 4'h0, 1'b0, 1'b0);
        checkOutput("rstw_wready_held", 128'(bus.AXI_WREADY), 128'(1'b0));
        rst = 1'b1;
        tick();
        rst = 1'b0;
        #1;
        checkOutput("rstw_wready", 128'(bus.AXI_WREADY), 128'(1'b1));
        applyStimulus(1'b1, 32'h64, 1'b0, 32'h0, 4'h0, 1'b0, 1'b0);
        tick();
        applyStimulus(1'b0, 32'h0, 1'b0, 32'h0, 4'h0, 1'b0, 1'b0);
        tick();
        checkOutput("rstw_no_bvalid", 128'(bus.AXI_BVALID), 128'(1'b0));
        applyStimulus(1'b0, 32'h0, 1'b1, 32'h5A5A5A5A, 4'hF, 1'b0, 1'b0);
        tick();
        applyStimulus(1'b0, 32'h0, 1'b0, 32'h0, 4'h0, 1'b0, 1'b0);
        checkOutput("rstw_bvalid", 128'(bus.AXI_BVALID), 128'(1'b1));
        tick();
        readLine(32'h60, 2'b00, "rd60");
        checkOutput("rd60_w0", 128'(lastLine[31:0]),  128'(32'h33333333));
        checkOutput("rd60_w1", 128'(lastLine[63:32]), 128'(32'h5A5A5A5A));

        // Zero-latency instance: RVALID on the cycle right after AR
        checkOutput("lat0_rvalid_idle", 128'(bus0.AXI_RVALID), 128'(1'b0));
        checkOutput("lat0_arready", 128'(bus0.AXI_ARREADY), 128'(1'b1));
        bus0.AXI_ARVALID = 1'b1;
        bus0.AXI_ARADDR  = 32'h1004;
        tick();
        bus0.AXI_ARVALID = 1'b0;
        checkOutput("lat0_rvalid", 128'(bus0.AXI_RVALID), 128'(1'b1));
        checkOutput("lat0_rdata",  bus0.AXI_RDATA,        128'h0);
        checkOutput("lat0_rresp",  128'(bus0.AXI_RRESP),  128'(2'b11));
        tick();
        checkOutput("lat0_done", 128'(bus0.AXI_RVALID), 128'(1'b0));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/d_mem_axi_responder.md
Name: d_mem_axi_responder

Overview:
- AXI-Lite-style slave memory model that terminates the data-cache AXI master port of the RV32IMF core top.
- Accepts single-word writes (AW/W/B channels), with byte/halfword qualifiers WR_Byte/WR_HWORD.
- Answers each read (AR) with a full D_WORD-word cache line on the R channel after a programmable latency.
- Used as the data-memory end in integration simulation and FPGA bring-up.

Parameters:
- XLEN, 32, data/address width.
- D_WORD, 4, words per cache line returned on RDATA.
- DEPTH_WORDS, 1024, memory size in 32-bit words; byte address range is 0 .. 4*DEPTH_WORDS-1.
- RD_LATENCY, 2, idle cycles between AR handshake and RVALID assertion (0 allowed).

Ports:
- CLK  in  1  clock.
- rst  in  1  synchronous, active-high reset.
- AXI_AWVALID  in  1  write address valid.
- AXI_AWADDR  in  XLEN  write byte address.
- AXI_AWPROT  in  3  ignored.
- AXI_AWCACHE  in  4  ignored.
- AXI_AWREADY  out  1  write address ready.
- AXI_WVALID  in  1  write data valid.
- AXI_WDATA  in  XLEN  write data, LSB-aligned for byte/halfword.
- AXI_WSTRB  in  4  byte strobes, full-word writes only.
- WR_Byte  in  1  byte write qualifier, sampled with the W beat.
- WR_HWORD  in  1  halfword write qualifier, sampled with the W beat.
- AXI_WREADY  out  1  write data ready.
- AXI_BVALID  out  1  write response valid.
- AXI_BRESP  out  2  write response: 00 OKAY, 10 SLVERR, 11 DECERR.
- AXI_BREADY  in  1  response ready.
- AXI_ARVALID  in  1  read address valid.
- AXI_ARADDR  in  XLEN  read byte address.
- AXI_ARPROT  in  3  ignored.
- AXI_ARCACHE  in  4  ignored.
- AXI_ARREADY  out  1  read address ready.
- AXI_RVALID  out  1  read data valid.
- AXI_RDATA  out  XLEN*D_WORD  line data; word i in bits [32i+31:32i].
- AXI_RRESP  out  2  read response.
- AXI_RREADY  in  1  read data ready.

Behaviour:

Interface and reset:
- One clock, CLK. Reset rst is synchronous and active-high.
- While rst is high, every output is 0: all READY/VALID signals, BRESP, RRESP and RDATA.
- Memory array contents are not reset.
- Reset mid-transaction aborts it: no write commits, a pending read is dropped, and both FSMs return to IDLE.

Write FSM (states W_IDLE, W_RESP):
- In W_IDLE, AWREADY = 1 while no address is latched, and WREADY = 1 while no data is latched.
- AW and W may complete in either order or in the same cycle. Each is latched on its own handshake.
- In the cycle after both are latched, commit the write and enter W_RESP with BVALID = 1.
- BVALID/BRESP are held until BREADY = 1. The B handshake returns to W_IDLE and clears both latches.
- AWREADY and WREADY are 0 while in W_RESP.

Write lanes:
- WR_Byte = 1: write WDATA[7:0] to byte lane ADDR[1:0].
- WR_HWORD = 1: write WDATA[15:0] to halfword lane ADDR[1].
- Neither set: write WDATA with lanes masked by WSTRB.
- If WR_Byte and WR_HWORD are both set, WR_Byte wins.

Write errors (no memory update in either case):
- Word index ADDR[XLEN-1:2] >= DEPTH_WORDS -> BRESP 11.
- Halfword write with ADDR[0] = 1 -> BRESP 10.

Read FSM (states R_IDLE, R_WAIT, R_DATA):
- R_IDLE: ARREADY = 1. An AR handshake latches the address, aligned down to a D_WORD*4-byte boundary (ADDR[3:0] cleared for the defaults).
- Then load the wait counter with RD_LATENCY. Go to R_WAIT, or straight to R_DATA when RD_LATENCY = 0.
- R_WAIT: decrement each cycle; leave for R_DATA when the count reaches 0. ARREADY = 0.
- The line is captured on entry to R_DATA. A write committing in that same cycle is not visible (read-old).
- R_DATA: RVALID = 1 with RDATA/RRESP held stable until RREADY = 1; the handshake returns to R_IDLE.
- RVALID rises exactly RD_LATENCY+1 cycles after the AR handshake cycle.
- If any word of the line is out of range: out-of-range words read 0 and RRESP = 11. Otherwise RRESP = 00.

Concurrency:
- Read and write FSMs run independently; simultaneous AR and AW/W are both accepted.
- At most one outstanding transaction per direction; no ID or burst support.

Test Plan:
- Full-word write AWADDR=0x40, WDATA=0xDEADBEEF, WSTRB=F, BREADY=1 -> BVALID one cycle after both handshakes, BRESP=00. Then read ARADDR=0x48 -> RVALID 3 cycles after AR, RDATA[31:0]=0xDEADBEEF (word 0 of line 0x40), RRESP=00.
- Byte/halfword writes to word 0x40 holding 0xDEADBEEF: WR_Byte at 0x41, WDATA=0x55 -> 0xDEAD55EF. WR_HWORD at 0x42, WDATA=0x1234 -> 0x123455EF. WR_HWORD at 0x43 -> BRESP=10, word unchanged.
- W beat two cycles before AW, then AW; and AW/W in the same cycle -> both commit identically. BREADY low for 5 cycles -> BVALID/BRESP held stable, AWREADY=WREADY=0 throughout.
- AWADDR=0x1000 (DEPTH 1024) -> BRESP=11, no write. ARADDR=0x1000 -> RDATA=0, RRESP=11.
- RREADY held low 4 cycles -> RDATA stable. Concurrent write to same line during R_WAIT -> visible; write committing in the R_DATA entry cycle -> not visible. RD_LATENCY=0 build -> RVALID the cycle after AR.
- rst asserted in W_RESP and in R_WAIT -> next cycle all outputs 0, FSMs idle. A write latched but not committed leaves memory unchanged.
